// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a two-entry skid buffer and flush.
// Define PIPE_STAGE_SKID_STATS_EN to enable the back-pressure stall counter.
module pipe_stage_skid #(
    parameter int                DATA_W      = 136,
    parameter int                CTRL_W      = 7,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occupancy_o,
    output logic [15:0]       stall_cnt_o
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_skid_in;
    logic              load_main_skid;

    // Handshake outputs depend on registered state only.
    assign in_ready_o  = (state_q != S_TWO);
    assign out_valid_o = (state_q != S_EMPTY);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    state_d      = S_ONE;
                    load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d      = S_TWO;
                    load_skid_in = 1'b1;
                end else if (out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_fire) begin
                    state_d        = S_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (flush_i) begin
            state_d      = S_EMPTY;
            load_main_in = 1'b0;
            load_skid_in = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            if (load_main_in) begin
                main_data_q <= in_data_i;
                main_ctrl_q <= in_ctrl_i;
            end else if (load_main_skid) begin
                main_data_q <= skid_data_q;
                main_ctrl_q <= skid_ctrl_q;
            end
            if (load_skid_in) begin
                skid_data_q <= in_data_i;
                skid_ctrl_q <= in_ctrl_i;
            end
        end
    end

    assign out_data_o  = main_data_q;
    assign out_ctrl_o  = out_valid_o ? main_ctrl_q : BUBBLE_CTRL;
    assign occupancy_o = state_q;

`ifdef PIPE_STAGE_SKID_STATS_EN
    logic [15:0] stall_cnt_q;

    // Survives flush so stalls can be profiled across pipeline redirects.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, handshaked pipeline stage register for the five-stage CPU datapath, replacing the fixed-field, always-advancing inter-stage latches. It carries an opaque data bundle plus a control bundle between stages with valid/ready flow control, a two-entry skid buffer so back-pressure never forms a combinational ready path, and a flush that inserts a bubble. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), each with its own widths.

## Interface
- DATA_W, 136: data bundle width (operands, immediate, register addresses, instruction).
- CTRL_W, 7: control bundle width (ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, ALUOp).
- BUBBLE_CTRL, {CTRL_W{1'b0}}: control value presented when the stage holds no valid entry.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  discard all held entries and the input offered this cycle.
- in_valid_i  in  1  upstream offers an entry.
- in_ready_o  out  1  stage accepts an entry this cycle.
- in_data_i  in  DATA_W  upstream data bundle.
- in_ctrl_i  in  CTRL_W  upstream control bundle.
- out_valid_o  out  1  stage presents an entry.
- out_ready_i  in  1  downstream accepts the presented entry.
- out_data_o  out  DATA_W  presented data bundle.
- out_ctrl_o  out  CTRL_W  presented control; BUBBLE_CTRL when out_valid_o=0.
- occupancy_o  out  2  entries held (0..2).
- stall_cnt_o  out  16  back-pressure cycle counter (see Configuration).

## Operation
- Storage: main register (drives outputs) and skid register; in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
- States: EMPTY (0 entries), ONE (main valid), TWO (main and skid valid).
- EMPTY: in_ready_o=1, out_valid_o=0. in_fire -> ONE, main <= input.
- ONE: in_ready_o=1, out_valid_o=1. in_fire & out_fire -> ONE, main <= input. in_fire & !out_fire -> TWO, skid <= input. !in_fire & out_fire -> EMPTY. Neither -> hold.
- TWO: in_ready_o=0, out_valid_o=1. out_fire -> ONE, main <= skid. Otherwise hold; entries never overwritten.
- Entries leave in arrival order; none dropped or duplicated except by flush.
- flush_i: next state EMPTY from any state; input offered that cycle is discarded even if in_ready_o=1; out_fire that cycle still counts as delivered.
- rst_i: EMPTY, main/skid data zero; priority over flush_i.
- out_data_o when invalid: retains last main value (don't-care for consumers); out_ctrl_o forced to BUBBLE_CTRL so a valid-unaware consumer sees a NOP.
- occupancy_o: 0/1/2 for EMPTY/ONE/TWO.

## Timing
- Latency: entry accepted in cycle N appears on out_*_o in cycle N+1 when stage was EMPTY or ONE with out_fire in N.
- Throughput: one entry per cycle with out_ready_i held high.
- in_ready_o and out_valid_o are functions of registered state only; no combinational path from out_ready_i or in_valid_i to any output. out_ctrl_o mux on out_valid_o is the sole combinational output logic.
- After a cycle with out_ready_i=0 in ONE and in_fire, in_ready_o drops next cycle; one extra entry absorbed by skid.
- Reset values: in_ready_o=1, out_valid_o=0, out_data_o=0, out_ctrl_o=BUBBLE_CTRL, occupancy_o=0, stall_cnt_o=0.

## Configuration
- PIPE_STAGE_SKID_STATS_EN defined: stall_cnt_o increments every cycle with out_valid_o=1 & out_ready_i=0, saturates at 16'hFFFF, cleared by rst_i only (not flush_i).
- Undefined: counter logic absent, stall_cnt_o tied to 0; all other behaviour identical.

## Test plan
- Reset: rst_i=1 two cycles with in_valid_i=1 -> out_valid_o=0, in_ready_o=1, out_ctrl_o=BUBBLE_CTRL, occupancy_o=0 throughout; data 0.
- Streaming: out_ready_i=1, send data 1..8 back-to-back -> out_data_o 1..8 on consecutive cycles, one cycle after acceptance, occupancy_o=1.
- Back-pressure: out_ready_i=0 while sending 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready_o=0 from third cycle, occupancy_o=2; release -> 0xA,0xB,0xC delivered in order, no loss.
- Flush: in TWO with in_valid_i=1, pulse flush_i -> next cycle out_valid_o=0, out_ctrl_o=BUBBLE_CTRL, occupancy_o=0; flushed input never appears.
- Reset vs flush: rst_i and flush_i together mid-stream -> reset values next cycle; stall_cnt_o=0.
- Stats (macro defined): hold out_ready_i=0 for 10 cycles with valid entry -> stall_cnt_o=10; flush -> still 10; macro undefined -> stays 0.
